// File: rtl/e203_subsys_rst_seq_pkg.sv
// Shared types and default parameters for the subsystem reset sequencer.
// Holds the release FSM encoding and the default channel/timing values.
package e203_subsys_rst_seq_pkg;

    localparam int E203_ASYNC_FF_LEVELS = 2;
    localparam int DEF_NCH              = 4;
    localparam int DEF_REL_DLY          = 8;
    localparam int DEF_SW_RST_CYC       = 16;

    typedef enum logic [1:0] {
        SEQ_HOLD    = 2'd0,
        SEQ_RELEASE = 2'd1,
        SEQ_DONE    = 2'd2
    } seq_state_e;

endpackage

// File: rtl/e203_subsys_rst_stretch.sv
// Per-channel reset output flop with a software-reset stretch counter.
// A request is accepted only once the channel has been released by the sequence.
module e203_subsys_rst_stretch
    import e203_subsys_rst_seq_pkg::*;
#(
    parameter int SW_RST_CYC = DEF_SW_RST_CYC
) (
    input  logic clk,
    input  logic rst_n_a,
    input  logic released,
    input  logic req,
    output logic rst_n_o,
    output logic busy
);

    localparam int              CW       = $clog2(SW_RST_CYC + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SW_RST_CYC - 1);

    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_rst_n;
    logic          w_accept;

    // Released-by-sequence is exactly "output high or currently stretching".
    assign w_accept = req & (r_rst_n | r_busy);

    // Stretch counter and channel output flop; a new request restarts the stretch.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_rst_n <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_rst_n <= 1'b0;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy  <= 1'b0;
                r_rst_n <= released;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end else begin
            r_rst_n <= released;
        end
    end

    assign rst_n_o = r_rst_n;
    assign busy    = r_busy;

endmodule

// File: rtl/e203_subsys_rst_seq.sv
// Multi-channel reset synchroniser and release sequencer: channels come out of
// reset one at a time in index order, each may be re-reset by software.
module e203_subsys_rst_seq
    import e203_subsys_rst_seq_pkg::*;
#(
    parameter int NCH        = DEF_NCH,
    parameter int SYNC_LEVEL = E203_ASYNC_FF_LEVELS,
    parameter int REL_DLY    = DEF_REL_DLY,
    parameter int SW_RST_CYC = DEF_SW_RST_CYC
) (
    input  logic           clk,
    input  logic           rst_n_a,
    input  logic           test_mode,
    input  logic [NCH-1:0] sw_rst_req,
    output logic [NCH-1:0] rst_n,
    output logic           rst_done,
    output logic [NCH-1:0] sw_busy
);

    localparam int            DW       = $clog2(REL_DLY + 1);
    localparam int            IW       = $clog2(NCH + 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(REL_DLY - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);

    logic [SYNC_LEVEL-1:0] r_sync;
    seq_state_e            r_state;
    logic [DW-1:0]         r_dly_cnt;
    logic [IW-1:0]         r_idx;
    logic                  r_rst_done;
    logic                  w_rst_sync_n;
    logic                  w_rel_now;
    logic [NCH-1:0]        w_released;
    logic [NCH-1:0]        w_rst_n;
    logic [NCH-1:0]        w_busy;

    // Deassertion synchroniser for the raw subsystem reset.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_LEVEL-2:0], 1'b1};
        end
    end

    assign w_rst_sync_n = r_sync[SYNC_LEVEL-1];
    assign w_rel_now    = (r_state == SEQ_RELEASE) && (r_dly_cnt == DLY_LAST);

    // Release sequencer: one channel every REL_DLY cycles, DONE is terminal.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            r_state    <= SEQ_HOLD;
            r_dly_cnt  <= '0;
            r_idx      <= '0;
            r_rst_done <= 1'b0;
        end else begin
            case (r_state)
                SEQ_HOLD: begin
                    if (w_rst_sync_n) begin
                        r_state   <= SEQ_RELEASE;
                        r_dly_cnt <= '0;
                        r_idx     <= '0;
                    end
                end
                SEQ_RELEASE: begin
                    if (w_rel_now) begin
                        r_dly_cnt <= '0;
                        r_idx     <= r_idx + IW'(1);
                        if (r_idx == IDX_LAST) begin
                            r_state    <= SEQ_DONE;
                            r_rst_done <= 1'b1;
                        end
                    end else begin
                        r_dly_cnt <= r_dly_cnt + DW'(1);
                    end
                end
                SEQ_DONE: begin
                    r_state <= SEQ_DONE;
                end
                default: begin
                    r_state    <= SEQ_HOLD;
                    r_dly_cnt  <= '0;
                    r_idx      <= '0;
                    r_rst_done <= 1'b0;
                end
            endcase
        end
    end

    // w_released includes the channel being released on this edge so its flop rises on time.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_released[i] = (r_state == SEQ_DONE) ||
                               ((r_state == SEQ_RELEASE) &&
                                ((r_idx > IW'(i)) || (w_rel_now && (r_idx == IW'(i)))));

        e203_subsys_rst_stretch #(
            .SW_RST_CYC (SW_RST_CYC)
        ) u_stretch (
            .clk      (clk),
            .rst_n_a  (rst_n_a),
            .released (w_released[i]),
            .req      (sw_rst_req[i]),
            .rst_n_o  (w_rst_n[i]),
            .busy     (w_busy[i])
        );
    end

    assign rst_n    = test_mode ? {NCH{rst_n_a}} : w_rst_n;
    assign rst_done = r_rst_done;
    assign sw_busy  = w_busy;

endmodule

// File: tb/tb_e203_subsys_rst_seq.sv
// Bench for e203_subsys_rst_seq: an edge-count model predicts every output each
// cycle; directed steps add hand-computed literal expectations.
module tb_e203_subsys_rst_seq;

    localparam int NCH = 4;
    localparam int SL  = 2;
    localparam int RD  = 8;
    localparam int SC  = 16;

    logic           clk        = 1'b0;
    logic           rst_n_a    = 1'b0;
    logic           test_mode  = 1'b0;
    logic [NCH-1:0] sw_rst_req = '0;
    logic [NCH-1:0] rst_n;
    logic           rst_done;
    logic [NCH-1:0] sw_busy;

    int checks = 0;
    int errors = 0;

    e203_subsys_rst_seq #(
        .NCH        (NCH),
        .SYNC_LEVEL (SL),
        .REL_DLY    (RD),
        .SW_RST_CYC (SC)
    ) dut (
        .clk        (clk),
        .rst_n_a    (rst_n_a),
        .test_mode  (test_mode),
        .sw_rst_req (sw_rst_req),
        .rst_n      (rst_n),
        .rst_done   (rst_done),
        .sw_busy    (sw_busy)
    );

    always #5 clk = ~clk;

    // Model: m_edge = index of the last clock edge since rst_n_a went high
    // (first edge seen high is edge 0); m_end[k] = edge at which a stretch ends.
    int m_edge = -1;
    int m_end[NCH] = '{default: -1000};

    function automatic int rel_edge(int k);
        return SL + (k + 1) * RD;
    endfunction

    always @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            m_edge = -1;
            for (int k = 0; k < NCH; k++) m_end[k] = -1000;
        end else begin
            for (int k = 0; k < NCH; k++)
                if (sw_rst_req[k] && (m_edge >= rel_edge(k)))
                    m_end[k] = m_edge + 1 + SC;
            m_edge = m_edge + 1;
        end
    end

    function automatic logic [NCH-1:0] exp_busy();
        logic [NCH-1:0] b;
        for (int k = 0; k < NCH; k++) b[k] = rst_n_a && (m_edge < m_end[k]);
        return b;
    endfunction

    function automatic logic [NCH-1:0] exp_rst_n();
        logic [NCH-1:0] r;
        for (int k = 0; k < NCH; k++)
            r[k] = test_mode ? rst_n_a
                             : (rst_n_a && (m_edge >= rel_edge(k)) && !(m_edge < m_end[k]));
        return r;
    endfunction

    function automatic logic exp_done();
        return rst_n_a && (m_edge >= SL + NCH * RD);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_rst_n", 32'(rst_n), 32'(exp_rst_n()));
        check("model_rst_done", 32'(rst_done), 32'(exp_done()));
        check("model_sw_busy", 32'(sw_busy), 32'(exp_busy()));
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tick(3);
        check("reset_rst_n", 32'(rst_n), 32'h0);
        check("reset_done", 32'(rst_done), 32'h0);
        check("reset_busy", 32'(sw_busy), 32'h0);

        // Power-up sequence: next edge after deassertion is edge 0.
        rst_n_a = 1'b1;
        tick(10);
        check("pu_edge9", 32'(rst_n), 32'h0);
        tick(1);
        check("pu_edge10", 32'(rst_n), 32'h1);
        tick(8);
        check("pu_edge18", 32'(rst_n), 32'h3);

        // Mid-sequence reset, then the full sequence again.
        tick(2);
        rst_n_a = 1'b0;
        #1;
        check("mid_rst_async", 32'(rst_n), 32'h0);
        check("mid_rst_done", 32'(rst_done), 32'h0);
        tick(3);
        rst_n_a = 1'b1;
        tick(16);
        sw_rst_req = 4'b1000;
        tick(1);
        sw_rst_req = 4'b0000;
        check("early_req_busy", 32'(sw_busy), 32'h0);
        tick(17);
        check("seq_edge33", 32'(rst_n), 32'h7);
        check("seq_edge33_done", 32'(rst_done), 32'h0);
        sw_rst_req = 4'b1000;
        tick(1);
        sw_rst_req = 4'b0000;
        check("seq_edge34", 32'(rst_n), 32'hF);
        check("seq_edge34_done", 32'(rst_done), 32'h1);
        check("req_on_release_edge", 32'(sw_busy), 32'h0);

        // Single software reset on channel 2.
        tick(2);
        sw_rst_req = 4'b0100;
        tick(1);
        sw_rst_req = 4'b0000;
        check("sw2_start", 32'(rst_n), 32'hB);
        check("sw2_busy", 32'(sw_busy), 32'h4);
        tick(15);
        check("sw2_cyc16", 32'(rst_n), 32'hB);
        tick(1);
        check("sw2_end", 32'(rst_n), 32'hF);
        check("sw2_end_busy", 32'(sw_busy), 32'h0);

        // Retrigger 10 cycles into the stretch: 26 cycles low overall.
        tick(2);
        sw_rst_req = 4'b0100;
        tick(1);
        sw_rst_req = 4'b0000;
        tick(9);
        sw_rst_req = 4'b0100;
        tick(1);
        sw_rst_req = 4'b0000;
        tick(15);
        check("retrig_cyc26", 32'(rst_n), 32'hB);
        tick(1);
        check("retrig_end", 32'(rst_n), 32'hF);

        // All channels at once.
        tick(2);
        sw_rst_req = 4'b1111;
        tick(1);
        sw_rst_req = 4'b0000;
        check("all_start", 32'(rst_n), 32'h0);
        check("all_busy", 32'(sw_busy), 32'hF);
        check("all_done_kept", 32'(rst_done), 32'h1);
        tick(15);
        check("all_cyc16", 32'(rst_n), 32'h0);
        tick(1);
        check("all_end", 32'(rst_n), 32'hF);
        check("all_end_busy", 32'(sw_busy), 32'h0);
        check("all_end_done", 32'(rst_done), 32'h1);

        // DFT bypass: outputs follow rst_n_a directly.
        test_mode = 1'b1;
        #1;
        check("tm_high", 32'(rst_n), 32'hF);
        rst_n_a = 1'b0;
        #1;
        check("tm_low", 32'(rst_n), 32'h0);
        rst_n_a = 1'b1;
        #1;
        check("tm_rise", 32'(rst_n), 32'hF);
        check("tm_done", 32'(rst_done), 32'h0);
        tick(2);
        check("tm_hold", 32'(rst_n), 32'hF);
        test_mode = 1'b0;
        #1;
        check("tm_off", 32'(rst_n), 32'h0);
        tick(40);
        check("final_done", 32'(rst_done), 32'h1);
        check("final_rst_n", 32'(rst_n), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
